multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Multicycle successor to the single-cycle decoder: FSM sequences FETCH/DECODE/EXEC/MEM/WB per instruction.
//  Stalls on a mem_ready handshake (APB-attached memory), flags illegal encodings and aborts hung accesses.
//  Sits between instruction register/ALU/regfile datapath and the bus-side memory port.
// PARAMETERS
//  OPCODE_W  4  opcode width; encodings below use the low 4 bits, upper bits must be 0 or op is illegal
//  FUNC_W    3  func width; R-type legal only for func 0..3
//  MAX_WAIT  16 max stall cycles per memory access before abort; 0 = never time out
// PORTS
//  clk          in  1         clock, all state on rising edge
//  rst          in  1         synchronous, active-high reset
//  opcode       in  OPCODE_W  from IR, valid from DECODE onward
//  func         in  FUNC_W    from IR, R-type sub-op
//  zero         in  1         ALU zero flag, sampled in EXEC for BEQ
//  mem_ready    in  1         memory completes current mem_read/mem_write this cycle
//  mem_read     out 1         instruction fetch (FETCH) or data load (MEM, LW)
//  mem_write    out 1         data store (MEM, SW)
//  ir_write     out 1         load IR; pulse in FETCH when mem_ready
//  pc_write     out 1         update PC this cycle
//  pc_src       out 2         00 PC+1, 01 branch target, 10 jump target
//  reg_write    out 1         regfile write (WB only)
//  reg_dst      out 1         1 rd (R-type), 0 rt
//  alusrc       out 1         0 register B, 1 immediate
//  alufn        out 3         000 ADD 001 SUB 010 AND 011 OR 100 ADDI 101 LW 110 SW 111 BEQ
//  mem_to_reg   out 1         1 ALU result, 0 memory data
//  illegal_op   out 1         1-cycle pulse, undecodable instruction
//  timeout_err  out 1         1-cycle pulse, memory access aborted
// BEHAVIOUR
//  Opcodes: R=0 (func ADD0 SUB1 AND2 OR3), ADDI=4, JMP=2, BEQ=8, LW=11, SW=15; all else illegal.
//  States: FETCH, DECODE, EXEC, MEM, WB. Outputs are combinational from state + latched op_q/func_q.
//  Unlisted outputs are 0 in every state; reg_dst/alusrc/mem_to_reg/alufn hold decode value DECODE..WB, else 0.
//  rst=1: next state FETCH, wait counter 0, op_q/func_q 0; all outputs 0 while rst is high.
//  Reset mid-operation: in-flight instruction dropped, no reg_write/mem_write after rst sampled.
//  FETCH: mem_read=1; if mem_ready: ir_write=1, pc_write=1, pc_src=00, ->DECODE; else stay, count++.
//  DECODE: latch opcode/func into op_q/func_q; illegal -> illegal_op=1, ->FETCH; legal -> EXEC.
//  EXEC: R/ADDI -> WB; LW/SW -> MEM; BEQ: pc_write=zero, pc_src=01, ->FETCH; JMP: pc_write=1, pc_src=10, ->FETCH.
//  MEM: LW mem_read=1 / SW mem_write=1; on mem_ready: LW->WB, SW->FETCH; else stay, count++.
//  WB: reg_write=1; mem_to_reg=0 for LW else 1; reg_dst=1 for R-type else 0; ->FETCH.
//  Min latency (zero-wait memory): BEQ/JMP 3, R/ADDI/SW 4, LW 5 cycles; each stall cycle adds 1.
//  Wait counter clears on entering FETCH or MEM and on mem_ready. MAX_WAIT>0 and count==MAX_WAIT-1
//   with mem_ready=0: timeout_err=1 that cycle, strobes still high, next state FETCH (no ir/pc/reg write).
//  mem_ready on the timeout cycle wins: normal completion, no timeout_err.
//  mem_ready outside FETCH/MEM ignored. mem_read/mem_write never both 1; strobes held stable while stalled.
//  ALU ops: alusrc=0 for R-type, 1 for ADDI/LW/SW/BEQ; BEQ compares with alufn=111 only.
// TESTING
//  rst held 3 cycles, mem_ready=1 -> all outputs 0 in reset; first post-reset cycle mem_read=1, ir_write=1.
//  ADD (op 0, func 0), mem_ready=1 -> 4 cycles, reg_write=1 reg_dst=1 mem_to_reg=1 alufn=000 in cycle 4.
//  LW (op 11), mem_ready low 2 cycles in MEM -> mem_read held 3 cycles, WB mem_to_reg=0, total 7 cycles.
//  BEQ zero=1 -> pc_write=1 pc_src=01 in EXEC; BEQ zero=0 -> pc_write=0, next FETCH after 3 cycles.
//  opcode 5, or op 0 func 6 -> illegal_op pulse in DECODE, no reg/mem write, back to FETCH.
//  MAX_WAIT=4, SW with mem_ready=0 -> mem_write 4 cycles, timeout_err on 4th, FETCH next; rst in MEM aborts.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB per instruction,
// stalls on mem_ready, flags illegal encodings and aborts hung memory accesses.
module multicycle_control_unit #(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned FUNC_W   = 3,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNC_W-1:0]   func,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                alusrc,
  output logic [2:0]          alufn,
  output logic                mem_to_reg,
  output logic                illegal_op,
  output logic                timeout_err
);

  // Counter only needs to reach MAX_WAIT-1; with MAX_WAIT==0 it simply wraps.
  localparam int unsigned CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

  localparam logic [3:0] OP_R    = 4'd0;
  localparam logic [3:0] OP_JMP  = 4'd2;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_LW   = 4'd11;
  localparam logic [3:0] OP_SW   = 4'd15;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB
  } state_t;

  typedef struct packed {
    logic       legal;
    logic       is_r;
    logic       is_addi;
    logic       is_jmp;
    logic       is_beq;
    logic       is_lw;
    logic       is_sw;
    logic       reg_dst;
    logic       alusrc;
    logic       mem_to_reg;
    logic [2:0] alufn;
  } dec_t;

  // Full decode of one instruction; anything not matched stays illegal (all zero).
  function automatic dec_t decode_op(input logic [OPCODE_W-1:0] op,
                                     input logic [FUNC_W-1:0]   fn);
    dec_t d;
    d = '0;
    if (op == OPCODE_W'(OP_R)) begin
      if (fn[FUNC_W-1:2] == '0) begin
        d.legal      = 1'b1;
        d.is_r       = 1'b1;
        d.reg_dst    = 1'b1;
        d.alusrc     = 1'b0;
        d.mem_to_reg = 1'b1;
        d.alufn      = {1'b0, fn[1:0]};
      end
    end else if (op == OPCODE_W'(OP_ADDI)) begin
      d.legal      = 1'b1;
      d.is_addi    = 1'b1;
      d.alusrc     = 1'b1;
      d.mem_to_reg = 1'b1;
      d.alufn      = 3'b100;
    end else if (op == OPCODE_W'(OP_JMP)) begin
      d.legal  = 1'b1;
      d.is_jmp = 1'b1;
    end else if (op == OPCODE_W'(OP_BEQ)) begin
      d.legal  = 1'b1;
      d.is_beq = 1'b1;
      d.alusrc = 1'b1;
      d.alufn  = 3'b111;
    end else if (op == OPCODE_W'(OP_LW)) begin
      d.legal  = 1'b1;
      d.is_lw  = 1'b1;
      d.alusrc = 1'b1;
      d.alufn  = 3'b101;
    end else if (op == OPCODE_W'(OP_SW)) begin
      d.legal  = 1'b1;
      d.is_sw  = 1'b1;
      d.alusrc = 1'b1;
      d.alufn  = 3'b110;
    end
    return d;
  endfunction

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] op_q;
  logic [FUNC_W-1:0]   func_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                at_limit;
  dec_t                dec;

  // Decode the live IR fields in DECODE (op_q is not yet loaded), latched ones afterwards.
  always_comb begin
    if (state_q == DECODE) begin
      dec = decode_op(opcode, func);
    end else begin
      dec = decode_op(op_q, func_q);
    end
  end

  // Stall limit reached on this cycle (never when MAX_WAIT is 0).
  always_comb begin
    at_limit = (MAX_WAIT != 0) && (cnt_q == CNT_W'(MAX_WAIT - 1));
  end

  // State, wait counter and latched instruction fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      op_q    <= '0;
      func_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == DECODE) begin
        op_q   <= opcode;
        func_q <= func;
      end
    end
  end

  // Next-state and control outputs from state and decoded instruction.
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    alusrc      = 1'b0;
    alufn       = 3'b000;
    mem_to_reg  = 1'b0;
    illegal_op  = 1'b0;
    timeout_err = 1'b0;

    if (state_q != FETCH) begin
      reg_dst    = dec.reg_dst;
      alusrc     = dec.alusrc;
      alufn      = dec.alufn;
      mem_to_reg = dec.mem_to_reg;
    end

    unique case (state_q)
      FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = 2'b00;
          state_d  = DECODE;
        end else if (at_limit) begin
          timeout_err = 1'b1;
          state_d     = FETCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DECODE: begin
        if (dec.legal) begin
          state_d = EXEC;
        end else begin
          illegal_op = 1'b1;
          state_d    = FETCH;
        end
      end

      EXEC: begin
        if (dec.is_r || dec.is_addi) begin
          state_d = WB;
        end else if (dec.is_lw || dec.is_sw) begin
          state_d = MEM;
        end else if (dec.is_beq) begin
          pc_write = zero;
          pc_src   = 2'b01;
          state_d  = FETCH;
        end else begin
          pc_write = dec.is_jmp;
          pc_src   = dec.is_jmp ? 2'b10 : 2'b00;
          state_d  = FETCH;
        end
      end

      MEM: begin
        mem_read  = dec.is_lw;
        mem_write = dec.is_sw;
        if (mem_ready) begin
          state_d = dec.is_lw ? WB : FETCH;
        end else if (at_limit) begin
          timeout_err = 1'b1;
          state_d     = FETCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end

      default: begin
        state_d = FETCH;
      end
    endcase

    // Nothing leaves the block while reset is asserted.
    if (rst) begin
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 2'b00;
      reg_write   = 1'b0;
      reg_dst     = 1'b0;
      alusrc      = 1'b0;
      alufn       = 3'b000;
      mem_to_reg  = 1'b0;
      illegal_op  = 1'b0;
      timeout_err = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: per-instruction cycle traces derived from the instruction
// set rules, compared every cycle against the DUT outputs.
module tb_multicycle_control_unit;

  localparam int MW = 4;

  localparam int C_ILL  = 0;
  localparam int C_R    = 1;
  localparam int C_ADDI = 2;
  localparam int C_JMP  = 3;
  localparam int C_BEQ  = 4;
  localparam int C_LW   = 5;
  localparam int C_SW   = 6;

  // Packed observation: {mem_read, mem_write, ir_write, pc_write, pc_src[1:0],
  //  reg_write, reg_dst, alusrc, alufn[2:0], mem_to_reg, illegal_op, timeout_err}
  localparam int B_MR  = 14;
  localparam int B_MW  = 13;
  localparam int B_IRW = 12;
  localparam int B_PCW = 11;
  localparam int B_RW  = 8;
  localparam int B_ILL = 1;
  localparam int B_TO  = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = '0;
  logic [2:0] func = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       mem_read, mem_write, ir_write, pc_write, reg_write;
  logic       reg_dst, alusrc, mem_to_reg, illegal_op, timeout_err;
  logic [1:0] pc_src;
  logic [2:0] alufn;
  logic [14:0] obs;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_idx;
  int rst_at;
  bit aborted;

  multicycle_control_unit #(
    .OPCODE_W (4),
    .FUNC_W   (3),
    .MAX_WAIT (MW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .func        (func),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .alusrc      (alusrc),
    .alufn       (alufn),
    .mem_to_reg  (mem_to_reg),
    .illegal_op  (illegal_op),
    .timeout_err (timeout_err)
  );

  assign obs = {mem_read, mem_write, ir_write, pc_write, pc_src, reg_write,
                reg_dst, alusrc, alufn, mem_to_reg, illegal_op, timeout_err};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  function automatic int classify(input logic [3:0] op, input logic [2:0] fn);
    case (op)
      4'd0:    return (fn < 3'd4) ? C_R : C_ILL;
      4'd4:    return C_ADDI;
      4'd2:    return C_JMP;
      4'd8:    return C_BEQ;
      4'd11:   return C_LW;
      4'd15:   return C_SW;
      default: return C_ILL;
    endcase
  endfunction

  // Decode-held fields {reg_dst, alusrc, alufn, mem_to_reg} and which of them are defined.
  task automatic ref_fields(input int cls, input logic [2:0] fn,
                            output logic [5:0] f, output logic [5:0] c);
    f = '0;
    c = '1;
    case (cls)
      C_R:    f = {1'b1, 1'b0, 1'b0, fn[1:0], 1'b1};
      C_ADDI: f = 6'b0_1_100_1;
      C_LW:   f = 6'b0_1_101_0;
      C_SW:   begin f = 6'b0_1_110_0; c = 6'b111110; end
      C_BEQ:  begin f = 6'b0_1_111_0; c = 6'b111110; end
      C_JMP:  c = 6'b100000;
      default: c = '0;
    endcase
  endtask

  // One clock cycle: drive mem_ready (or a planned reset), compare at negedge.
  task automatic step(input logic rdy, input logic [14:0] exp_in,
                      input logic [14:0] care_in, input string tag);
    logic [14:0] exp;
    logic [14:0] care;
    exp  = exp_in;
    care = care_in;
    cyc_idx++;
    mem_ready = rdy;
    if (cyc_idx == rst_at) begin
      rst     = 1'b1;
      exp     = '0;
      care    = '1;
      aborted = 1'b1;
    end else begin
      rst = 1'b0;
    end
    @(negedge clk);
    check(aborted ? "rst_abort" : tag, obs & care, exp & care);
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction: fw/mw are not-ready cycles before mem_ready in FETCH/MEM.
  task automatic run_instr(input logic [3:0] op, input logic [2:0] fn, input logic z,
                           input int fw, input int mw, input int rst_cycle);
    int cls;
    int n;
    logic [5:0] f;
    logic [5:0] fc;
    logic [14:0] exp;
    logic [14:0] care;
    logic rdy;

    cyc_idx = 0;
    rst_at  = rst_cycle;
    aborted = 1'b0;
    opcode  = 4'($urandom);
    func    = 3'($urandom);
    zero    = 1'($urandom);

    n = (fw < MW) ? fw + 1 : MW;
    for (int i = 0; i < n; i++) begin
      rdy = (i == fw);
      exp = '0;
      exp[B_MR]  = 1'b1;
      exp[B_IRW] = rdy;
      exp[B_PCW] = rdy;
      exp[B_TO]  = !rdy && (i == MW - 1);
      step(rdy, exp, '1, "fetch");
      if (aborted) return;
    end
    if (fw >= MW) return;

    opcode = op;
    func   = fn;
    cls    = classify(op, fn);
    ref_fields(cls, fn, f, fc);
    care = '1;
    care[7:2] = fc;

    exp = '0;
    exp[7:2]   = f;
    exp[B_ILL] = (cls == C_ILL);
    step(1'($urandom), exp, care, "decode");
    if (aborted || cls == C_ILL) return;

    zero = z;
    exp = '0;
    exp[7:2] = f;
    if (cls == C_BEQ) begin
      exp[B_PCW]  = z;
      exp[10:9]   = 2'b01;
    end else if (cls == C_JMP) begin
      exp[B_PCW]  = 1'b1;
      exp[10:9]   = 2'b10;
    end
    step(1'($urandom), exp, care, "exec");
    zero = 1'($urandom);
    if (aborted || cls == C_BEQ || cls == C_JMP) return;

    if (cls == C_LW || cls == C_SW) begin
      n = (mw < MW) ? mw + 1 : MW;
      for (int i = 0; i < n; i++) begin
        rdy = (i == mw);
        exp = '0;
        exp[7:2] = f;
        exp[B_MR] = (cls == C_LW);
        exp[B_MW] = (cls == C_SW);
        exp[B_TO] = !rdy && (i == MW - 1);
        step(rdy, exp, care, "mem");
        if (aborted) return;
      end
      if (mw >= MW || cls == C_SW) return;
    end

    exp = '0;
    exp[7:2]  = f;
    exp[B_RW] = 1'b1;
    step(1'($urandom), exp, care, "wb");
  endtask

  function automatic int rand_wait();
    return ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, MW + 1));
  endfunction

  initial begin
    logic [3:0] legal_ops [6];
    logic [3:0] op;
    legal_ops = '{4'd0, 4'd4, 4'd2, 4'd8, 4'd11, 4'd15};

    rst = 1'b1;
    mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("reset", obs, '0);
    end
    @(posedge clk);
    #1;

    run_instr(4'd0,  3'd0, 1'b0, 0, 0, 0);       // ADD
    run_instr(4'd0,  3'd1, 1'b0, 0, 0, 0);       // SUB
    run_instr(4'd11, 3'd0, 1'b0, 0, 2, 0);       // LW with two stalls
    run_instr(4'd8,  3'd0, 1'b1, 0, 0, 0);       // BEQ taken
    run_instr(4'd8,  3'd0, 1'b0, 0, 0, 0);       // BEQ not taken
    run_instr(4'd2,  3'd0, 1'b0, 1, 0, 0);       // JMP after fetch stall
    run_instr(4'd5,  3'd0, 1'b0, 0, 0, 0);       // illegal opcode
    run_instr(4'd0,  3'd6, 1'b0, 0, 0, 0);       // illegal R func
    run_instr(4'd15, 3'd0, 1'b0, 0, MW, 0);      // SW timeout
    run_instr(4'd15, 3'd0, 1'b0, 0, MW - 1, 0);  // ready on limit cycle wins
    run_instr(4'd0,  3'd0, 1'b0, MW, 0, 0);      // fetch timeout
    run_instr(4'd15, 3'd0, 1'b0, 0, 9, 5);       // reset while stalled in MEM
    run_instr(4'd11, 3'd0, 1'b0, 0, 0, 5);       // reset in LW writeback
    run_instr(4'd4,  3'd0, 1'b0, 0, 0, 0);       // ADDI after reset

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) != 0) op = legal_ops[$urandom_range(0, 5)];
      else op = 4'($urandom);
      run_instr(op, 3'($urandom), 1'($urandom), rand_wait(), rand_wait(),
                ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 8)) : 0);
    end
    run_instr(4'd0, 3'd3, 1'b0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
